cfa_raster_ctrl: RTL and testbench
==================================

Name: cfa_raster_ctrl

Overview:
- Raster sequencer that sits directly upstream of bayer_color.
- Accepts a raw-sensor pixel stream over a valid/ready handshake and re-presents it one stage later on a registered output.
- Counts row and column for each pixel and generates the start / rowUpdate / colUpdate pulses that bayer_color consumes.
- Pulse timing keeps bayerSymbol aligned to the pixel currently on m_data. Also flags malformed lines.

Parameters:
DATA_W, 12, raw pixel width in bits
COL_W, 12, column counter / frame_width width (max 4095 pixels per line)
ROW_W, 12, row counter / frame_height width (max 4095 lines)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
frame_start  in  1  one-cycle request to begin a frame; honoured only in IDLE
frame_width  in  COL_W  pixels per line; sampled at frame_start
frame_height  in  ROW_W  lines per frame; sampled at frame_start
s_valid  in  1  input pixel valid
s_ready  out  1  input pixel accepted when s_valid & s_ready
s_data  in  DATA_W  input pixel
s_eol  in  1  sensor end-of-line marker on the input pixel
m_valid  out  1  output pixel valid
m_ready  in  1  downstream accept
m_data  out  DATA_W  registered pixel
m_col  out  COL_W  column index of m_data
m_row  out  ROW_W  row index of m_data
start  out  1  to bayer_color: load pattern
rowUpdate  out  1  to bayer_color: next line
colUpdate  out  1  to bayer_color: next column
busy  out  1  high in ACTIVE
frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted downstream
cfg_err  out  1  one-cycle pulse when frame_start is rejected for bad size
eol_err  out  1  sticky; set on s_eol mismatch, cleared by the next accepted frame_start or reset

Behaviour:
- Reset (rst=0 at a clock edge): state IDLE. All outputs 0, including m_valid, start, pulses, counters and eol_err. Any in-flight pixel is discarded.
- FSM states: IDLE, ACTIVE.
- IDLE:
  - s_ready=0.
  - frame_start with frame_width>=2 and frame_height>=2: latch the sizes, zero the counters, clear eol_err, drive start=1 for exactly one cycle, go to ACTIVE next cycle.
  - frame_start with frame_width<2 or frame_height<2: pulse cfg_err, stay in IDLE, no start.
- ACTIVE, output register:
  - One-entry output register. s_ready = ~m_valid | m_ready (pass-through ready).
  - On input handshake: m_data<=s_data and m_valid<=1. m_col/m_row take the values of the input-side counters.
  - Latency: exactly 1 cycle from input accept to m_valid.
- ACTIVE, input-side counters:
  - Advance on each input handshake: column increments; at column frame_width-1 it wraps to 0 and the row increments.
  - After the pixel at (frame_width-1, frame_height-1) is accepted, s_ready is forced to 0 until the frame completes.
- Control pulses: combinational from the output handshake (m_valid & m_ready), mutually exclusive.
  - m_col < frame_width-1: colUpdate=1.
  - m_col = frame_width-1 and m_row < frame_height-1: rowUpdate=1.
  - m_col = frame_width-1 and m_row = frame_height-1: frame_done=1, then IDLE next cycle (m_valid cleared unless refilled; no refill is possible).
  - Result: bayer_color state always corresponds to the pixel on m_data, since its update lands on the same edge the next pixel loads.
- Stall: m_valid=1 and m_ready=0 holds m_data/m_col/m_row stable. No pulses are issued.
- Line marker check: on input handshake, s_eol must equal (input column == frame_width-1).
  - On mismatch, set eol_err. Counters are not resynchronised; the frame continues.
- frame_start in ACTIVE is ignored: no start, no cfg_err.
- rst=0 mid-frame: immediate return to IDLE with all outputs 0. The next frame needs a new frame_start.
- Counter arithmetic is unsigned. Widths never overflow because sizes are at most 2^COL_W-1 and 2^ROW_W-1.

Test Plan:
- rst=0 for 2 cycles, then rst=1 -> all outputs 0, s_ready=0, state IDLE.
- frame_start with 4x2 frame, 8 pixels 0x001..0x008 streamed with s_valid=1, m_ready=1:
  - start pulses once before the first pixel.
  - m_data follows input by 1 cycle.
  - colUpdate on pixels (0..2,row0) and (0..2,row1); rowUpdate on (3,0).
  - frame_done on (3,1); bayer_color pattern RGGB yields R,G,R,G,G,B,G,B.
- Same frame, m_ready low for 3 cycles on pixel (1,0) -> m_data=0x002 held and no pulses during the stall; s_ready=0; total pulse count unchanged (6 col, 1 row, 1 frame_done).
- s_eol=1 on pixel (2,0) of a 4x2 frame -> eol_err=1 from the next cycle and stays 1 through frame_done; next valid frame_start clears it.
- frame_start with frame_width=1 -> cfg_err one cycle, no start, busy=0. frame_start during ACTIVE -> ignored.
- rst=0 after 3 pixels of a 4x2 frame -> m_valid=0 and busy=0 next cycle. A new frame_start then restarts at (0,0) with a single start pulse.

Source files
------------

// File: rtl/cfa_raster_ctrl.sv
// Raster sequencer feeding bayer_color: registers the raw pixel stream one stage
// and emits start/rowUpdate/colUpdate so the Bayer phase tracks the pixel on m_data.
module cfa_raster_ctrl #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned COL_W  = 12,
  parameter int unsigned ROW_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [COL_W-1:0]  frame_width,
  input  logic [ROW_W-1:0]  frame_height,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_eol,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [COL_W-1:0]  m_col,
  output logic [ROW_W-1:0]  m_row,
  output logic              start,
  output logic              rowUpdate,
  output logic              colUpdate,
  output logic              busy,
  output logic              frame_done,
  output logic              cfg_err,
  output logic              eol_err
);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_ACTIVE = 1'b1;

  logic              r_state;
  logic [COL_W-1:0]  r_width;
  logic [ROW_W-1:0]  r_height;
  logic [COL_W-1:0]  r_in_col;
  logic [ROW_W-1:0]  r_in_row;
  logic              r_in_done;
  logic [DATA_W-1:0] r_m_data;
  logic [COL_W-1:0]  r_m_col;
  logic [ROW_W-1:0]  r_m_row;
  logic              r_m_valid;
  logic              r_start;
  logic              r_cfg_err;
  logic              r_eol_err;

  logic w_size_ok;
  logic w_fs_accept;
  logic w_fs_reject;
  logic w_s_hs;
  logic w_m_hs;
  logic w_in_last_col;
  logic w_in_last_row;
  logic w_out_last_col;
  logic w_out_last_row;

  assign w_size_ok   = (frame_width >= COL_W'(2)) && (frame_height >= ROW_W'(2));
  assign w_fs_accept = (r_state == ST_IDLE) && frame_start && w_size_ok;
  assign w_fs_reject = (r_state == ST_IDLE) && frame_start && !w_size_ok;

  // Input stops after the last pixel of the frame until it drains downstream.
  assign s_ready = (r_state == ST_ACTIVE) && !r_in_done && (!r_m_valid || m_ready);
  assign w_s_hs  = s_valid && s_ready;
  assign w_m_hs  = r_m_valid && m_ready;

  assign w_in_last_col  = (r_in_col == r_width - COL_W'(1));
  assign w_in_last_row  = (r_in_row == r_height - ROW_W'(1));
  assign w_out_last_col = (r_m_col == r_width - COL_W'(1));
  assign w_out_last_row = (r_m_row == r_height - ROW_W'(1));

  // Pulses fire on the output handshake so bayer_color advances on the same
  // edge that loads the next pixel into m_data.
  assign colUpdate  = w_m_hs && !w_out_last_col;
  assign rowUpdate  = w_m_hs && w_out_last_col && !w_out_last_row;
  assign frame_done = w_m_hs && w_out_last_col && w_out_last_row;

  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_col   = r_m_col;
  assign m_row   = r_m_row;
  assign start   = r_start;
  assign cfg_err = r_cfg_err;
  assign eol_err = r_eol_err;
  assign busy    = (r_state == ST_ACTIVE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_width   <= '0;
      r_height  <= '0;
      r_in_col  <= '0;
      r_in_row  <= '0;
      r_in_done <= 1'b0;
      r_m_data  <= '0;
      r_m_col   <= '0;
      r_m_row   <= '0;
      r_m_valid <= 1'b0;
      r_start   <= 1'b0;
      r_cfg_err <= 1'b0;
      r_eol_err <= 1'b0;
    end else begin
      r_start   <= w_fs_accept;
      r_cfg_err <= w_fs_reject;
      case (r_state)
        ST_IDLE: begin
          if (w_fs_accept) begin
            r_width   <= frame_width;
            r_height  <= frame_height;
            r_in_col  <= '0;
            r_in_row  <= '0;
            r_in_done <= 1'b0;
            r_m_col   <= '0;
            r_m_row   <= '0;
            r_m_valid <= 1'b0;
            r_eol_err <= 1'b0;
            r_state   <= ST_ACTIVE;
          end
        end
        default: begin
          if (w_s_hs) begin
            r_m_data  <= s_data;
            r_m_col   <= r_in_col;
            r_m_row   <= r_in_row;
            r_m_valid <= 1'b1;
            if (s_eol != w_in_last_col)
              r_eol_err <= 1'b1;
            if (w_in_last_col) begin
              r_in_col <= '0;
              if (w_in_last_row)
                r_in_done <= 1'b1;
              else
                r_in_row <= r_in_row + ROW_W'(1);
            end else begin
              r_in_col <= r_in_col + COL_W'(1);
            end
          end else if (w_m_hs) begin
            r_m_valid <= 1'b0;
          end
          if (frame_done) begin
            r_m_valid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfa_raster_ctrl.sv
// Scoreboard bench for cfa_raster_ctrl: pixels pushed on input accept, popped on
// output accept, with a small bayer_color phase model driven by the pulses.
module tb_cfa_raster_ctrl;

  localparam int DW = 12;
  localparam int CW = 12;
  localparam int RW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          frame_start = 1'b0;
  logic [CW-1:0] frame_width = '0;
  logic [RW-1:0] frame_height = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_eol = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [CW-1:0] m_col;
  logic [RW-1:0] m_row;
  logic          start, rowUpdate, colUpdate, busy, frame_done, cfg_err, eol_err;

  always #5 clk = ~clk;

  cfa_raster_ctrl #(.DATA_W(DW), .COL_W(CW), .ROW_W(RW)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .frame_width(frame_width), .frame_height(frame_height),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_eol(s_eol),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_col(m_col), .m_row(m_row),
    .start(start), .rowUpdate(rowUpdate), .colUpdate(colUpdate),
    .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err), .eol_err(eol_err)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic [RW-1:0] r;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;
  int cur_w = 4, cur_h = 2;
  int mdl_col = 0, mdl_row = 0;
  logic exp_eol = 1'b0;
  logic bay_r = 1'b0, bay_c = 1'b0;
  int n_start = 0, n_col = 0, n_row = 0, n_done = 0, n_cfg = 0;
  logic last_s_hs = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    logic ec, er, ed;
    last_s_hs = 1'b0;
    if (!rst) begin
      sb.delete();
      exp_eol = 1'b0;
      return;
    end
    if (cfg_err) n_cfg++;
    if (start) begin
      n_start++;
      mdl_col = 0; mdl_row = 0;
      exp_eol = 1'b0;
      bay_r = 1'b0; bay_c = 1'b0;
    end
    check("eol_err", 32'(eol_err), 32'(exp_eol));
    if (m_valid) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb[0];
        check("m_data", 32'(m_data), 32'(e.d));
        check("m_col", 32'(m_col), 32'(e.c));
        check("m_row", 32'(m_row), 32'(e.r));
        if (m_ready) begin
          void'(sb.pop_front());
          check("bayer_sym", 32'({bay_r, bay_c}), 32'({e.r[0], e.c[0]}));
          ec = (int'(e.c) < cur_w - 1);
          er = (int'(e.c) == cur_w - 1) && (int'(e.r) < cur_h - 1);
          ed = (int'(e.c) == cur_w - 1) && (int'(e.r) == cur_h - 1);
          check("pulses", 32'({colUpdate, rowUpdate, frame_done}), 32'({ec, er, ed}));
          if (colUpdate) begin n_col++; bay_c = ~bay_c; end
          if (rowUpdate) begin n_row++; bay_r = ~bay_r; bay_c = 1'b0; end
          if (frame_done) n_done++;
        end else begin
          check("stall_pulses", 32'({colUpdate, rowUpdate, frame_done}), 32'd0);
          check("stall_s_ready", 32'(s_ready), 32'd0);
        end
      end
    end else begin
      check("idle_pulses", 32'({colUpdate, rowUpdate, frame_done}), 32'd0);
    end
    if (s_valid && s_ready) begin
      last_s_hs = 1'b1;
      e.d = s_data; e.c = CW'(mdl_col); e.r = RW'(mdl_row);
      sb.push_back(e);
      if (s_eol != (mdl_col == cur_w - 1)) exp_eol = 1'b1;
      if (mdl_col == cur_w - 1) begin mdl_col = 0; mdl_row++; end
      else mdl_col++;
    end
  endtask

  // Samples at the falling edge, then returns 1ns after the next rising edge.
  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int w, input int h, input int stall_n,
                           input int bad_idx, input int fs_mid_idx, input int abort_idx);
    int idx;
    int stall_left;
    cur_w = w; cur_h = h;
    n_start = 0; n_col = 0; n_row = 0; n_done = 0; n_cfg = 0;
    frame_width = CW'(w); frame_height = RW'(h);
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    check("start_pulse", 32'(start), 32'd1);
    check("busy_active", 32'(busy), 32'd1);
    idx = 0;
    stall_left = stall_n;
    for (int k = 0; k < 200 && n_done == 0; k++) begin
      if (abort_idx >= 0 && idx >= abort_idx) break;
      s_valid = (idx < w * h);
      s_data = DW'(idx + 1);
      s_eol = ((idx % w) == w - 1) ^ (idx == bad_idx);
      frame_start = (idx == fs_mid_idx) && (k > 0) && !frame_start;
      if (stall_left > 0 && m_valid && m_col == CW'(1) && m_row == RW'(0)) begin
        m_ready = 1'b0;
        stall_left--;
      end else begin
        m_ready = 1'b1;
      end
      cycle();
      if (last_s_hs) idx++;
    end
    s_valid = 1'b0; s_eol = 1'b0; frame_start = 1'b0;
    if (abort_idx < 0) begin
      check("frame_done_seen", 32'(n_done), 32'd1);
      check("busy_after_done", 32'(busy), 32'd0);
      check("m_valid_after_done", 32'(m_valid), 32'd0);
      check("start_count", 32'(n_start), 32'd1);
      check("col_count", 32'(n_col), 32'((w - 1) * h));
      check("row_count", 32'(n_row), 32'(h - 1));
      check("cfg_err_count", 32'(n_cfg), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk); #1;
    cycle();
    cycle();
    check("rst_flags", 32'({s_ready, m_valid, start, rowUpdate, colUpdate,
                             busy, frame_done, cfg_err, eol_err}), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_col", 32'(m_col), 32'd0);
    check("rst_m_row", 32'(m_row), 32'd0);
    rst = 1'b1;
    cycle();
    check("idle_s_ready", 32'(s_ready), 32'd0);

    // Plain 4x2 frame, then the same frame with a 3-cycle stall on (1,0).
    run_frame(4, 2, 0, -1, -1, -1);
    cycle();
    run_frame(4, 2, 3, -1, -1, -1);
    cycle();

    // Bad line marker on pixel (2,0): sticky through frame_done.
    run_frame(4, 2, 0, 2, -1, -1);
    check("eol_err_sticky", 32'(eol_err), 32'd1);
    cycle();
    check("eol_err_idle", 32'(eol_err), 32'd1);
    run_frame(4, 2, 0, -1, -1, -1);
    check("eol_err_cleared", 32'(eol_err), 32'd0);
    cycle();

    // Undersized frames are rejected.
    frame_width = CW'(1); frame_height = RW'(2); frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    check("cfg_err_w1", 32'({cfg_err, start, busy, s_ready}), 32'b1000);
    cycle();
    check("cfg_err_pulse_end", 32'(cfg_err), 32'd0);
    frame_width = CW'(4); frame_height = RW'(1); frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    check("cfg_err_h1", 32'({cfg_err, start, busy}), 32'b100);
    cycle();

    // frame_start while ACTIVE is ignored (start/cfg_err counts checked in run_frame).
    run_frame(4, 2, 0, -1, 3, -1);
    cycle();

    // Reset mid-frame after 3 pixels, then a clean restart.
    run_frame(4, 2, 0, -1, -1, 3);
    rst = 1'b0;
    cycle();
    check("abort_state", 32'({m_valid, busy, start, colUpdate, rowUpdate, frame_done}), 32'd0);
    rst = 1'b1;
    cycle();
    check("abort_idle", 32'({m_valid, busy, s_ready}), 32'd0);
    run_frame(4, 2, 0, -1, -1, -1);
    cycle();

    // Wider frame with a stall exercises longer rows.
    run_frame(5, 3, 3, -1, -1, -1);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
